// File: rtl/regfile_2r1w_param.sv
// Two-read/one-write register file with registered reads, optional write-first bypass,
// byte enables, optional hard-wired zero entry and a post-reset clearing sequencer.
module regfile_2r1w_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   read_addr1,
  input  logic [ADDR_W-1:0]   read_addr2,
  output logic [DATA_W-1:0]   read_data1,
  output logic [DATA_W-1:0]   read_data2,
  output logic                rd_valid,
  output logic                ready,
  output logic                state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clear_ptr_q, clear_ptr_d;
  logic [DATA_W-1:0]   read_data1_q, read_data1_d;
  logic [DATA_W-1:0]   read_data2_q, read_data2_d;
  logic                rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   bit_mask;
  logic [DATA_W-1:0]   wr_merged;
  logic                wr_accept;
  logic                hit1, hit2;
  logic [DATA_W-1:0]   rd_word1, rd_word2;

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      bit_mask[8*i +: 8] = {8{wr_be[i]}};
    end
  end

  // Post-write word: enabled bytes from wr_data, the rest from the current entry.
  assign wr_merged = (wr_data & bit_mask) | (mem_q[wr_addr] & ~bit_mask);
  assign wr_accept = (state_q == ST_RUN) && wr_en &&
                     !((ZERO_REG != 0) && (wr_addr == '0));

  assign hit1 = (BYPASS != 0) && wr_accept && (wr_addr == read_addr1);
  assign hit2 = (BYPASS != 0) && wr_accept && (wr_addr == read_addr2);

  assign rd_word1 = ((ZERO_REG != 0) && (read_addr1 == '0)) ? '0 :
                    hit1 ? wr_merged : mem_q[read_addr1];
  assign rd_word2 = ((ZERO_REG != 0) && (read_addr2 == '0)) ? '0 :
                    hit2 ? wr_merged : mem_q[read_addr2];

  always_comb begin
    state_d      = state_q;
    clear_ptr_d  = clear_ptr_q;
    read_data1_d = read_data1_q;
    read_data2_d = read_data2_q;
    rd_valid_d   = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = clear_ptr_q;
    mem_wdata    = '0;
    if (state_q == ST_INIT) begin
      mem_we      = 1'b1;
      clear_ptr_d = clear_ptr_q + 1'b1;
      if (clear_ptr_q == ADDR_W'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end else begin
      if (wr_accept) begin
        mem_we    = 1'b1;
        mem_waddr = wr_addr;
        mem_wdata = wr_merged;
      end
      if (rd_en) begin
        rd_valid_d   = 1'b1;
        read_data1_d = rd_word1;
        read_data2_d = rd_word2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      clear_ptr_q  <= '0;
      read_data1_q <= '0;
      read_data2_q <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_ptr_q  <= clear_ptr_d;
      read_data1_q <= read_data1_d;
      read_data2_q <= read_data2_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // The array has no reset; the INIT sequencer clears it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign read_data1 = read_data1_q;
  assign read_data2 = read_data2_q;
  assign rd_valid   = rd_valid_q;
  assign ready      = (state_q == ST_RUN);
  assign state_dbg  = (state_q == ST_RUN);

endmodule

// File: doc/regfile_2r1w_param.md
Name: regfile_2r1w_param

Overview:
Parametrised multi-port register file: one write port and two read ports, intended as the next-generation operand store feeding the FP ALU modules (IEEE-754 single-precision words by default). Adds over the earlier fixed 32x32 memory:
- registered reads with a valid strobe;
- write-to-read bypass;
- per-byte write enables;
- optional hard-wired zero register;
- a self-clearing initialisation sequencer that runs after reset.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
BYPASS, 1, 1 = write-first on same-cycle read/write collision; 0 = read-old.
ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
wr_en  input  1  write request.
wr_addr  input  ADDR_W  write address.
wr_data  input  DATA_W  write data.
wr_be  input  DATA_W/8  byte enables; bit i covers data bits [8i+7:8i].
rd_en  input  1  read request, applies to both read ports.
read_addr1  input  ADDR_W  read port 1 address.
read_addr2  input  ADDR_W  read port 2 address.
read_data1  output  DATA_W  read port 1 data, registered.
read_data2  output  DATA_W  read port 2 data, registered.
rd_valid  output  1  one-cycle pulse, read_data1/2 updated this cycle.
ready  output  1  1 = initialisation done, requests accepted.

Behaviour:
- Reset: rst low asynchronously forces read_data1/2=0, rd_valid=0, ready=0, FSM=INIT, clear pointer=0. The array is not asynchronously cleared.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle after rst deasserts, write 0 to entry[clear_ptr] and increment clear_ptr.
  - At clear_ptr==DEPTH-1, write that entry and go to RUN. ready=1 from the following cycle, i.e. DEPTH cycles after rst release.
  - wr_en and rd_en are ignored in INIT; rd_valid stays 0.
- RUN, write:
  - When wr_en=1, bytes with wr_be[i]=1 are updated at the clock edge. Other bytes are unchanged.
  - wr_be=0 is a legal no-op.
  - With ZERO_REG=1, writes to address 0 are discarded.
- RUN, read:
  - When rd_en=1, addresses are sampled at the edge. read_data1/2 are valid after that edge (latency 1) and rd_valid=1 for that cycle.
  - When rd_en=0, read_data1/2 hold their last value and rd_valid=0.
- Collision (wr_en, rd_en, wr_addr==read_addrN, same edge):
  - BYPASS=1: read_dataN returns the post-write word. Enabled bytes come from wr_data, the rest from the old entry.
  - BYPASS=0: read_dataN returns the pre-write word.
  - Both ports may collide simultaneously; each is handled independently.
- Both read ports may address the same entry and return identical data.
- ZERO_REG=1: reads of address 0 return 0, including under collision.
- Reset mid-operation (in INIT or RUN): immediate return to INIT, clear_ptr=0, full re-clear. Array contents before re-clear are don't-care.
- Address wrap: none; all ADDR_W values are legal entries.

Test Plan:
- Init timing: release rst at cycle 0, DATA_W=32, ADDR_W=5 -> ready rises at cycle 32. A read of any address after ready returns 0x00000000 with rd_valid=1 one cycle after rd_en.
- Basic write/read:
  - writes: addr 18 <= 0x40200000 (2.5), addr 13 <= 0xC1433333 (-12.2), addr 19 <= 0x40A00000 (5), all wr_be=4'hF.
  - read (19,13) -> 0x40A00000 / 0xC1433333 next cycle.
  - read (18,18) -> 0x40200000 on both ports.
- Byte enables: addr 18 holds 0x40200000; write 0xFFFFFFFF with wr_be=4'b0101 -> read returns 0x40FF00FF.
- Collision: BYPASS=1, write addr 13 <= 0x3F800000 and read (13,13) on the same edge -> both ports 0x3F800000. Repeat with BYPASS=0 -> both ports return 0xC1433333.
- Zero register: ZERO_REG=1, write addr 0 <= 0x12345678 -> read addr 0 returns 0. Requests issued during INIT have no effect and rd_valid stays 0.
- Reset mid-run: after the writes above, pulse rst low for 3 cycles -> outputs 0 immediately, ready=0 for 32 cycles, then all entries read 0.
